// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with selectable standard / first-word-
// fall-through read, registered occupancy count, almost-full / almost-empty
// thresholds, synchronous flush and overflow / underflow pulses.
// Optional statistics (peak_count, drop_count, stats_clr) are built only when
// the macro FIFO_STATS_EN is defined; otherwise those outputs are tied to 0.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   peak_count,
    output logic [15:0]           drop_count,
    input  logic                  stats_clr
);

    localparam int                DEPTH     = 1 << ADDR_WIDTH;
    localparam bit                FWFT_MODE = (FWFT != 0);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] CNT_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_LEVEL  = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_LEVEL  = (ADDR_WIDTH + 1)'(AE_THRESH);

    // Thresholds outside 0..DEPTH would make a flag stuck or meaningless.
    generate
        if (AF_THRESH < 0 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_bad_thresh
            $error("sync_fifo_param: AF_THRESH/AE_THRESH must lie within 0..DEPTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;

    logic flush;         // rst or clear: return to the empty state
    logic mem_empty;     // storage array holds no word
    logic mem_rd;        // move the word at rd_ptr into the dout register
    logic pop;           // a word leaves the FIFO (count decrements)
    logic wr_accept;     // a word enters the FIFO (count increments)
    logic overflow_set;  // write attempted while full
    logic underflow_set; // read attempted with nothing to read

    assign flush     = rst || clear;
    assign mem_empty = (wr_ptr == rd_ptr);

    generate
        if (FWFT_MODE) begin : g_fwft
            // dout acts as a prefetch register for the head word; it is
            // refilled whenever it is vacant or being popped, so back-to-back
            // pops stream without bubbles. count includes the prefetched word,
            // so fullness is taken from count rather than from the pointers.
            assign full   = (count_q == CNT_DEPTH);
            assign empty  = !valid;
            assign pop    = rd_en && valid;
            assign mem_rd = !mem_empty && (!valid || rd_en);
        end else begin : g_std
            // Same index with opposite wrap bit means the pointers are a full
            // lap apart.
            assign full   = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                            (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
            assign empty  = mem_empty;
            assign pop    = rd_en && !mem_empty;
            assign mem_rd = pop;
        end
    endgenerate

    // A write into a full FIFO is refused even if a read frees a slot in the
    // same cycle; this keeps full a purely registered decision.
    assign wr_accept     = wr_en && !full && !flush;
    assign overflow_set  = wr_en && full;
    assign underflow_set = rd_en && empty;

    // Storage array write port.
    // NOTE: the data array has no reset; only pointers and flags define which
    // entries are meaningful, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
        end
    end

    // Pointers, occupancy, read data register and status pulses.
    // NOTE: every register here uses <= so all updates see the pre-edge values
    // of full/empty/count regardless of statement order.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            dout      <= '0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + CNT_ONE;
            end
            if (mem_rd) begin
                rd_ptr <= rd_ptr + CNT_ONE;
                dout   <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
            case ({wr_accept, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (FWFT_MODE) begin
                valid <= mem_rd || (valid && !rd_en);
            end else begin
                valid <= mem_rd;
            end
            overflow  <= overflow_set;
            underflow <= underflow_set;
        end
    end

    assign count        = count_q;
    assign almost_full  = (count_q >= AF_LEVEL);
    assign almost_empty = (count_q <= AE_LEVEL);

`ifdef FIFO_STATS_EN
    logic [ADDR_WIDTH:0] peak_q;
    logic [15:0]         drop_q;

    // High-water mark and saturating rejected-write counter; clear leaves them.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            peak_q <= '0;
            drop_q <= '0;
        end else begin
            if (count_q > peak_q) begin
                peak_q <= count_q;
            end
            if (overflow_set && !clear && drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign peak_count = peak_q;
    assign drop_count = drop_q;
`else
    logic stats_clr_unused;
    assign stats_clr_unused = stats_clr;
    assign peak_count       = '0;
    assign drop_count       = '0;
`endif

endmodule
